clock_enable_bank: RTL
======================

Name: clock_enable_bank

Overview:
- N-channel successor to the single fixed-ratio divider. Each channel has a runtime-programmable divisor, a 50%-duty (or nearest) square output, and a one-cycle clock-enable strobe.
- Divisor changes are glitch-free: a new value takes effect only at a period boundary.
- Adds per-channel enable and a global phase-realign input.
- Feeds the century-clock timebase: seconds tick, display multiplex, buzzer tone and debounce sampling, all from the system clock.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
DIV_W, 26, width of divisor and counters
DEFAULT_DIV, 50_000_000, divisor loaded into every channel at reset (1 <= DEFAULT_DIV < 2^DIV_W)
SEL_W, (NUM_CH<=1)?1:$clog2(NUM_CH), width of div_sel (derived; not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ch_en  in  NUM_CH  per-channel run enable
sync_clr  in  1  restart all channel counters from phase 0
div_wr  in  1  divisor write strobe
div_sel  in  SEL_W  channel addressed by div_wr
div_data  in  DIV_W  new divisor value D (>=1)
div_pending  out  NUM_CH  written divisor not yet active
div_err  out  1  one-cycle pulse: rejected write
clk_out  out  NUM_CH  square wave, period D cycles
ce_out  out  NUM_CH  one-cycle strobe, once per period

Behaviour:
- Reset (async, rst_n=0): per channel, active=shadow=DEFAULT_DIV and cnt=0. clk_out, ce_out, div_pending and div_err are all 0. Reset mid-period forces outputs 0 immediately.
- All outputs are registered; no combinational path from inputs to outputs.
- Counting (ch_en[i]=1, sync_clr=0): cnt goes 0..D-1 and wraps to 0.
  - ce_out[i]=1 in the cycle following the edge at which cnt wraps D-1->0; otherwise 0.
  - clk_out[i] = (cnt >= L) evaluated on the registered cnt, with L = D>>1. Result: low for floor(D/2) cycles, then high for ceil(D/2) cycles, starting low after wrap.
  - D=1: ce_out high every enabled cycle; clk_out constant 1.
- Disabled (ch_en[i]=0): cnt held 0; clk_out and ce_out 0. Any pending divisor is applied at the next edge.
  - On re-enable, counting starts from cnt=0, so the first ce_out follows D enabled edges.
- Divisor write (div_wr=1):
  - Valid when div_sel<NUM_CH and div_data!=0: shadow[sel]<=div_data and div_pending[sel]<=1 on the next edge.
  - Invalid (either condition fails): no state change; div_err=1 for one cycle.
  - A second write before the value applies overwrites shadow; the last write wins.
- Apply point: active<=shadow and div_pending<=0 at the edge where cnt wraps D-1->0, or when the channel is disabled, or on sync_clr. The period in flight always completes with the old D.
- Write on a channel in the same cycle as its apply point: div_data loads directly into active (and shadow); pending ends 0.
- sync_clr=1: every channel gets cnt<=0, clk_out<=0, ce_out<=0, and all pendings are applied.
  - sync_clr has priority over wrap.
  - A simultaneous div_wr is still stored and applied in that same edge.
- Channels with equal D, enabled or cleared on the same edge, stay exactly in phase indefinitely.
- Arithmetic is unsigned DIV_W-bit; cnt never exceeds D-1. Divisor changes never produce a high or low phase shorter than min(old, new) half-period (no runt pulses).

Test Plan:
1. NUM_CH=4, DIV_W=8, DEFAULT_DIV=10, all ch_en=1 from reset release -> ce_out high after edges 10, 20, 30; clk_out low for 5 cycles then high for 5, identical on all 4 channels.
2. Write D=7 to ch1 at edge 13 -> div_pending[1] high from edge 14 to edge 20. ce_out[1] fires after edges 20, 27, 34; clk_out[1] low 3, high 4. Other channels unaffected.
3. Write D=1 to ch2 -> after the current period ends, ce_out[2] is high every cycle and clk_out[2] stays 1. Dropping ch_en[2] gives 0/0 on the next edge.
4. div_data=0 (and, with NUM_CH=3, div_sel=3) -> div_err pulses exactly one cycle; divisors, pendings and outputs unchanged.
5. Channels at D=10 and D=4 with offset phases, plus a pending D=6 on ch3, then pulse sync_clr -> all cnt=0; ch3 now uses D=6. The equal-D channels emit ce_out on the same cycle, 10 edges later.
6. Assert rst_n=0 asynchronously mid-period with pendings set -> all outputs 0 without waiting for a clock edge. After release, all channels are back at D=10 with no pendings, and the first ce_out follows 10 edges.

Source files
------------

// File: rtl/clock_enable_bank.sv
// Bank of independent programmable clock dividers. Each channel produces a near-50% square
// wave and a one-cycle enable strobe. A new divisor is held in a shadow register and takes effect at a period boundary.
module clock_enable_bank #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 50_000_000,
  parameter int SEL_W       = (NUM_CH <= 1) ? 1 : $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_data,
  output logic [NUM_CH-1:0] div_pending,
  output logic              div_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ce_out
);

  localparam int SEL_N = 1 << SEL_W;

  // A select code is valid only if it addresses an existing channel.
  function automatic logic [SEL_N-1:0] sel_mask();
    logic [SEL_N-1:0] m;
    m = '0;
    for (int i = 0; i < SEL_N; i++) m[i] = (i < NUM_CH);
    return m;
  endfunction

  localparam logic [SEL_N-1:0] SEL_VALID = sel_mask();
  localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0]  cnt_q    [NUM_CH];
  logic [DIV_W-1:0]  cnt_d    [NUM_CH];
  logic [DIV_W-1:0]  active_q [NUM_CH];
  logic [DIV_W-1:0]  active_d [NUM_CH];
  logic [DIV_W-1:0]  shadow_q [NUM_CH];
  logic [DIV_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic              err_q, err_d;

  logic wr_ok;
  logic run, wrap, apply, wr_hit;

  assign wr_ok = SEL_VALID[div_sel] && (div_data != '0);

  // NOTE: every variable written here gets a value on every pass, so no latch is inferred.
  always_comb begin
    err_d  = div_wr && !wr_ok;
    run    = 1'b0;
    wrap   = 1'b0;
    apply  = 1'b0;
    wr_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      run    = ch_en[i] && !sync_clr;
      wrap   = run && (cnt_q[i] == active_q[i] - DIV_W'(1));
      apply  = sync_clr || !ch_en[i] || wrap;
      wr_hit = div_wr && wr_ok && (32'(div_sel) == i);
      // A write landing on the apply edge goes straight through to the active divisor.
      shadow_d[i] = wr_hit ? div_data : shadow_q[i];
      active_d[i] = apply ? shadow_d[i] : active_q[i];
      pend_d[i]   = apply ? 1'b0 : (pend_q[i] || wr_hit);
      cnt_d[i]    = (run && !wrap) ? cnt_q[i] + DIV_W'(1) : '0;
      ce_d[i]     = wrap;
      clk_d[i]    = run && (cnt_d[i] >= (active_d[i] >> 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the per-channel arrays are only NUM_CH words of flops, so they are reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        active_q[i] <= RST_DIV;
        shadow_q[i] <= RST_DIV;
      end
      pend_q <= '0;
      clk_q  <= '0;
      ce_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        active_q[i] <= active_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      ce_q   <= ce_d;
      err_q  <= err_d;
    end
  end

  assign div_pending = pend_q;
  assign div_err     = err_q;
  assign clk_out     = clk_q;
  assign ce_out      = ce_q;

endmodule
